cond_exec_stage: RTL and testbench

- Execute-stage register and conditional-execution unit. Sits directly downstream of the instruction decoder in the pipelined ARM datapath.
- Latches the decoder's D-stage controls into E on each clock and evaluates the instruction's 4-bit condition field against the architectural NZCV flag register.
- Gates the side-effecting controls (register write, memory write, PC write, branch, link) and updates the flags from the ALU.
- Produces BranchTakenE/PCSrcE for the fetch stage and the hazard unit.

---
 rtl/cond_exec_stage.sv | 162 ++++++++++++++++
 tb/tb_cond_exec_stage.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/cond_exec_stage.sv
// Execute-stage pipeline register with ARM conditional execution.
// Latches decoder controls, gates side effects on the NZCV condition and updates the flags.
module cond_exec_stage #(
    parameter int COND_W   = 4,
    parameter int BYTEEN_W = 4
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                StallE,
    input  logic                FlushE,
    input  logic [COND_W-1:0]   CondD,
    input  logic                PCSD,
    input  logic                RegWD,
    input  logic                MemWD,
    input  logic                MemtoRegD,
    input  logic                ALUSrcD,
    input  logic                BranchD,
    input  logic                BranchLinkEnD,
    input  logic [1:0]          FlagWD,
    input  logic [3:0]          ALUControlD,
    input  logic [BYTEEN_W-1:0] ByteEnD,
    input  logic [3:0]          ALUFlags,
    output logic [3:0]          ALUControlE,
    output logic [BYTEEN_W-1:0] ByteEnE,
    output logic                MemtoRegE,
    output logic                ALUSrcE,
    output logic                CondExE,
    output logic                RegWriteE,
    output logic                MemWriteE,
    output logic                PCSrcE,
    output logic                BranchTakenE,
    output logic                BranchLinkE,
    output logic [3:0]          Flags
);

    // Pass/fail of a condition field against an {N,Z,C,V} flag set.
    function automatic logic f_cond_pass(input logic [COND_W-1:0] cond, input logic [3:0] nzcv);
        logic n, z, c, v;
        logic pass;
        {n, z, c, v} = nzcv;
        case (cond)
            4'b0000: pass = z;
            4'b0001: pass = ~z;
            4'b0010: pass = c;
            4'b0011: pass = ~c;
            4'b0100: pass = n;
            4'b0101: pass = ~n;
            4'b0110: pass = v;
            4'b0111: pass = ~v;
            4'b1000: pass = c & ~z;
            4'b1001: pass = ~c | z;
            4'b1010: pass = (n == v);
            4'b1011: pass = (n != v);
            4'b1100: pass = ~z & (n == v);
            4'b1101: pass = z | (n != v);
            4'b1110: pass = 1'b1;
            default: pass = 1'b0;
        endcase
        return pass;
    endfunction

    logic                r_valid;
    logic [COND_W-1:0]   r_cond;
    logic                r_pcs;
    logic                r_regw;
    logic                r_memw;
    logic                r_memtoreg;
    logic                r_alusrc;
    logic                r_branch;
    logic                r_blink;
    logic [1:0]          r_flagw;
    logic [3:0]          r_aluctl;
    logic [BYTEEN_W-1:0] r_byteen;
    logic [3:0]          r_flags;

    logic w_condex;
    logic w_pcsrc;
    logic w_squash;
    logic w_flag_upd;

    // Condition result and the squash of the wrong-path instruction behind a taken PC write.
    always_comb begin
        w_condex   = r_valid & f_cond_pass(r_cond, r_flags);
        w_pcsrc    = r_pcs & w_condex;
        w_squash   = w_pcsrc & ~StallE;
        w_flag_upd = w_condex & ~StallE;
    end

    // E register: bubble on flush/squash, hold on stall, otherwise capture D.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_valid    <= 1'b0;
            r_cond     <= {COND_W{1'b0}};
            r_pcs      <= 1'b0;
            r_regw     <= 1'b0;
            r_memw     <= 1'b0;
            r_memtoreg <= 1'b0;
            r_alusrc   <= 1'b0;
            r_branch   <= 1'b0;
            r_blink    <= 1'b0;
            r_flagw    <= 2'b00;
            r_aluctl   <= 4'b0000;
            r_byteen   <= {BYTEEN_W{1'b0}};
        end else if (FlushE || w_squash) begin
            r_valid    <= 1'b0;
            r_cond     <= {COND_W{1'b0}};
            r_pcs      <= 1'b0;
            r_regw     <= 1'b0;
            r_memw     <= 1'b0;
            r_memtoreg <= 1'b0;
            r_alusrc   <= 1'b0;
            r_branch   <= 1'b0;
            r_blink    <= 1'b0;
            r_flagw    <= 2'b00;
            r_aluctl   <= 4'b0000;
            r_byteen   <= {BYTEEN_W{1'b0}};
        end else if (!StallE) begin
            r_valid    <= 1'b1;
            r_cond     <= CondD;
            r_pcs      <= PCSD;
            r_regw     <= RegWD;
            r_memw     <= MemWD;
            r_memtoreg <= MemtoRegD;
            r_alusrc   <= ALUSrcD;
            r_branch   <= BranchD;
            r_blink    <= BranchLinkEnD;
            r_flagw    <= FlagWD;
            r_aluctl   <= ALUControlD;
            r_byteen   <= ByteEnD;
        end
    end

    // Architectural flags: only an executing, non-stalled instruction writes them.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_flags <= 4'b0000;
        end else if (w_flag_upd) begin
            if (r_flagw[1]) begin
                r_flags[3:2] <= ALUFlags[3:2];
            end
            if (r_flagw[0]) begin
                r_flags[1:0] <= ALUFlags[1:0];
            end
        end
    end

    // Output mapping: pass-through fields and condition-gated side effects.
    always_comb begin
        ALUControlE  = r_aluctl;
        ByteEnE      = r_byteen;
        MemtoRegE    = r_memtoreg;
        ALUSrcE      = r_alusrc;
        CondExE      = w_condex;
        RegWriteE    = r_regw & w_condex;
        MemWriteE    = r_memw & w_condex;
        PCSrcE       = w_pcsrc;
        BranchTakenE = r_branch & w_condex;
        BranchLinkE  = r_blink & w_condex;
        Flags        = r_flags;
    end

endmodule

// File: tb/tb_cond_exec_stage.sv
// Randomized and directed bench for cond_exec_stage against a behavioural pipeline model.
module tb_cond_exec_stage;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       StallE, FlushE;
    logic [3:0] CondD;
    logic       PCSD, RegWD, MemWD, MemtoRegD, ALUSrcD, BranchD, BranchLinkEnD;
    logic [1:0] FlagWD;
    logic [3:0] ALUControlD, ByteEnD, ALUFlags;
    logic [3:0] ALUControlE, ByteEnE, Flags;
    logic       MemtoRegE, ALUSrcE, CondExE, RegWriteE, MemWriteE, PCSrcE, BranchTakenE, BranchLinkE;

    int checks = 0;
    int failures = 0;

    typedef struct {
        bit       valid;
        bit [3:0] cond;
        bit       pcs, regw, memw, m2r, asrc, br, bl;
        bit [1:0] fw;
        bit [3:0] aluc, be;
    } instr_t;

    instr_t m_e;
    bit     mN, mZ, mC, mV;

    cond_exec_stage #(.COND_W(4), .BYTEEN_W(4)) dut (
        .clk(clk), .reset_n(reset_n), .StallE(StallE), .FlushE(FlushE),
        .CondD(CondD), .PCSD(PCSD), .RegWD(RegWD), .MemWD(MemWD),
        .MemtoRegD(MemtoRegD), .ALUSrcD(ALUSrcD), .BranchD(BranchD),
        .BranchLinkEnD(BranchLinkEnD), .FlagWD(FlagWD), .ALUControlD(ALUControlD),
        .ByteEnD(ByteEnD), .ALUFlags(ALUFlags), .ALUControlE(ALUControlE),
        .ByteEnE(ByteEnE), .MemtoRegE(MemtoRegE), .ALUSrcE(ALUSrcE),
        .CondExE(CondExE), .RegWriteE(RegWriteE), .MemWriteE(MemWriteE),
        .PCSrcE(PCSrcE), .BranchTakenE(BranchTakenE), .BranchLinkE(BranchLinkE),
        .Flags(Flags)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // ARM condition table written from the architectural meaning of each mnemonic.
    function automatic bit model_pass(input bit [3:0] cond);
        bit ge, ugt;
        ge  = (mN == mV);
        ugt = mC && !mZ;
        case (cond)
            4'd0:  return mZ;
            4'd1:  return !mZ;
            4'd2:  return mC;
            4'd3:  return !mC;
            4'd4:  return mN;
            4'd5:  return !mN;
            4'd6:  return mV;
            4'd7:  return !mV;
            4'd8:  return ugt;
            4'd9:  return !ugt;
            4'd10: return ge;
            4'd11: return !ge;
            4'd12: return !mZ && ge;
            4'd13: return mZ || !ge;
            4'd14: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic bit model_exec();
        return m_e.valid && model_pass(m_e.cond);
    endfunction

    task automatic model_reset();
        m_e = '{default: '0};
        {mN, mZ, mC, mV} = 4'b0000;
    endtask

    task automatic check_outputs(input string tag);
        bit ex;
        ex = model_exec();
        check_val({tag, ".pass"}, {6'b0, ALUControlE, ByteEnE, MemtoRegE, ALUSrcE},
                  {6'b0, m_e.aluc, m_e.be, m_e.m2r, m_e.asrc});
        check_val({tag, ".gated"}, {10'b0, CondExE, RegWriteE, MemWriteE, PCSrcE, BranchTakenE, BranchLinkE},
                  {10'b0, ex, m_e.regw && ex, m_e.memw && ex, m_e.pcs && ex, m_e.br && ex, m_e.bl && ex});
        check_val({tag, ".flags"}, {12'b0, Flags}, {12'b0, mN, mZ, mC, mV});
    endtask

    // One clock: advance the model with the current inputs, then compare at the falling edge.
    task automatic cycle(input string tag);
        bit ex, kill;
        instr_t d;
        @(posedge clk);
        ex   = model_exec();
        kill = FlushE || (m_e.pcs && ex && !StallE);
        if (ex && !StallE) begin
            if (m_e.fw[1]) {mN, mZ} = ALUFlags[3:2];
            if (m_e.fw[0]) {mC, mV} = ALUFlags[1:0];
        end
        d = '{valid: 1'b1, cond: CondD, pcs: PCSD, regw: RegWD, memw: MemWD, m2r: MemtoRegD,
              asrc: ALUSrcD, br: BranchD, bl: BranchLinkEnD, fw: FlagWD, aluc: ALUControlD, be: ByteEnD};
        if (kill) m_e = '{default: '0};
        else if (!StallE) m_e = d;
        @(negedge clk);
        check_outputs(tag);
    endtask

    task automatic idle_inputs();
        StallE = 1'b0; FlushE = 1'b0; CondD = 4'b1110; PCSD = 1'b0; RegWD = 1'b0;
        MemWD = 1'b0; MemtoRegD = 1'b0; ALUSrcD = 1'b0; BranchD = 1'b0;
        BranchLinkEnD = 1'b0; FlagWD = 2'b00; ALUControlD = 4'b0000; ByteEnD = 4'b0000;
    endtask

    initial begin
        reset_n  = 1'b0;
        ALUFlags = 4'b0000;
        idle_inputs();
        model_reset();
        repeat (2) @(negedge clk);
        check_outputs("reset_held");
        reset_n = 1'b1;

        // Reset asserted mid-cycle while a register write is live in E.
        RegWD = 1'b1;
        cycle("cap_regw");
        check_val("regw_live", {15'b0, RegWriteE}, 16'd1);
        #2 reset_n = 1'b0;
        model_reset();
        #1 check_outputs("async_reset");
        check_val("async_regw", {15'b0, RegWriteE}, 16'd0);
        @(negedge clk);
        reset_n = 1'b1;
        idle_inputs();
        cycle("post_reset");
        check_val("flags_after_reset", {12'b0, Flags}, 16'h0000);

        // Full flag write, then EQ/NE against it.
        FlagWD = 2'b11; ALUFlags = 4'b0100;
        cycle("set_flags");
        FlagWD = 2'b00; CondD = 4'b0000; RegWD = 1'b1;
        cycle("eq");
        check_val("flags_0100", {12'b0, Flags}, 16'h0004);
        check_val("eq_regw", {15'b0, RegWriteE}, 16'd1);
        CondD = 4'b0001;
        cycle("ne");
        check_val("ne_regw", {15'b0, RegWriteE}, 16'd0);

        // Partial update: only N,Z written.
        idle_inputs(); FlagWD = 2'b11;
        cycle("p1");
        ALUFlags = 4'b1111; FlagWD = 2'b10;
        cycle("p2");
        ALUFlags = 4'b0000; FlagWD = 2'b00;
        cycle("p3");
        check_val("partial_flags", {12'b0, Flags}, 16'h0003);

        // Taken branch squashes the following instruction.
        BranchD = 1'b1; PCSD = 1'b1;
        cycle("branch");
        check_val("br_taken", {14'b0, BranchTakenE, PCSrcE}, 16'h0003);
        BranchD = 1'b0; PCSD = 1'b0; RegWD = 1'b1;
        cycle("squash");
        check_val("squash_bubble", {14'b0, CondExE, RegWriteE}, 16'h0000);

        // Three-cycle stall of a flag-setting AL instruction.
        idle_inputs(); FlagWD = 2'b11; ALUControlD = 4'b1010; ALUFlags = 4'b1000;
        cycle("stall_cap");
        StallE = 1'b1; ALUControlD = 4'b0101; FlagWD = 2'b00;
        for (int i = 0; i < 3; i++) begin
            cycle("stall");
            check_val("stall_flags", {12'b0, Flags}, 16'h0003);
            check_val("stall_hold", {12'b0, ALUControlE}, 16'h000A);
        end
        StallE = 1'b0;
        cycle("stall_rel");
        check_val("stall_rel_flags", {12'b0, Flags}, 16'h0008);

        // Flush with stall: bubble, no flag write.
        idle_inputs(); FlagWD = 2'b11;
        cycle("fs_cap");
        StallE = 1'b1; FlushE = 1'b1; ALUFlags = 4'b0110;
        cycle("flush_stall");
        check_val("fs_bubble", {15'b0, CondExE}, 16'd0);
        check_val("fs_flags", {12'b0, Flags}, 16'h0008);

        // Never-execute condition.
        idle_inputs(); CondD = 4'b1111; MemWD = 1'b1;
        cycle("nv");
        check_val("nv_mem", {14'b0, MemWriteE, CondExE}, 16'h0000);

        // Randomized phase.
        for (int i = 0; i < 600; i++) begin
            StallE        = ($urandom_range(0, 3) == 0);
            FlushE        = ($urandom_range(0, 9) == 0);
            CondD         = ($urandom_range(0, 2) == 0) ? 4'b1110 : 4'($urandom_range(0, 15));
            PCSD          = ($urandom_range(0, 5) == 0);
            BranchD       = PCSD && $urandom_range(0, 1);
            BranchLinkEnD = BranchD && $urandom_range(0, 1);
            RegWD         = 1'($urandom_range(0, 1));
            MemWD         = 1'($urandom_range(0, 1));
            MemtoRegD     = 1'($urandom_range(0, 1));
            ALUSrcD       = 1'($urandom_range(0, 1));
            FlagWD        = 2'($urandom_range(0, 3));
            ALUControlD   = 4'($urandom_range(0, 15));
            ByteEnD       = 4'($urandom_range(0, 15));
            ALUFlags      = 4'($urandom_range(0, 15));
            cycle("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
